// File: rtl/rv_control_fsm_hs.sv
// Multicycle RV32I control sequencer with a ready/valid memory port.
// Drives datapath selects, sequences fetch/execute/memory phases, performs
// sub-word store read-modify-write, and traps on illegal, misaligned,
// SYSTEM and bus-timeout conditions.
//
// Memory handshake: mem_req_o is the valid. Once raised in FETCH, MEM_RD or
// MEM_WR it stays high, with addr_sel/mem_we/mem_be/dout_sel stable, until
// the cycle in which mem_ready_i is high; that cycle completes the transfer.
// mem_ready_i is ignored whenever mem_req_o is low. The only early drop is a
// bus-timeout abort, which traps and halts.
module rv_control_fsm_hs #(
   parameter int unsigned TIMEOUT_CYCLES  = 255,
   parameter bit          RMW_SUBWORD     = 1'b1,
   parameter bit          HALT_ON_ILLEGAL = 1'b1,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [6:0]       ir_opcode_i,
   input  logic [2:0]       ir_funct3_i,
   input  logic [6:0]       ir_funct7_i,
   input  logic             alt_b_i,
   input  logic             aeq_b_i,
   input  logic [1:0]       addr_lo_i,
   input  logic             mem_ready_i,
   output logic [1:0]       pc_sel_o,
   output logic             ir_load_o,
   output logic [1:0]       reg_sel_o,
   output logic             reg_en_o,
   output logic             alu_sel0_o,
   output logic             alu_sel1_o,
   output logic [3:0]       alu_op_o,
   output logic             addr_sel_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [3:0]       mem_be_o,
   output logic             tmp_load_o,
   output logic             dout_sel_o,
   output logic             un_signed_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] instret_o,
   output logic [2:0]       state_o
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int unsigned TO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_EXEC   = 3'd1,
      S_MEM_RD = 3'd2,
      S_MEM_WR = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             boot_q;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [1:0]       cause_q, cause_d;
   logic             retire;

   logic             illegal, is_mem, misaligned, subword_st, taken;
   logic             dec_sel0, dec_sel1;
   logic [3:0]       dec_op;
   logic             timeout;

   // Instruction decode: legality, alignment, branch outcome and ALU selects.
   always_comb begin
      illegal = 1'b0;
      case (ir_opcode_i)
         OPC_OP:     if (!(ir_funct7_i == 7'h00 ||
                          (ir_funct7_i == 7'h20 && (ir_funct3_i == 3'b000 || ir_funct3_i == 3'b101))))
                        illegal = 1'b1;
         OPC_OPIMM:  if ((ir_funct3_i == 3'b001 && ir_funct7_i != 7'h00) ||
                         (ir_funct3_i == 3'b101 && ir_funct7_i != 7'h00 && ir_funct7_i != 7'h20))
                        illegal = 1'b1;
         OPC_LOAD:   if (ir_funct3_i == 3'b011 || ir_funct3_i[2:1] == 2'b11) illegal = 1'b1;
         OPC_STORE:  if (ir_funct3_i[2] || ir_funct3_i[1:0] == 2'b11) illegal = 1'b1;
         OPC_BRANCH: if (ir_funct3_i[2:1] == 2'b01) illegal = 1'b1;
         OPC_JALR:   if (ir_funct3_i != 3'b000) illegal = 1'b1;
         OPC_FENCE:  if (ir_funct3_i != 3'b000) illegal = 1'b1;
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: illegal = 1'b0;
         default:    illegal = 1'b1;
      endcase

      is_mem     = (ir_opcode_i == OPC_LOAD) || (ir_opcode_i == OPC_STORE);
      misaligned = is_mem && (((ir_funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00)) ||
                              ((ir_funct3_i[1:0] == 2'b01) && addr_lo_i[0]));
      subword_st = (ir_opcode_i == OPC_STORE) && (ir_funct3_i[1:0] != 2'b10);

      case (ir_funct3_i)
         3'b000:         taken = aeq_b_i;
         3'b001:         taken = !aeq_b_i;
         3'b100, 3'b110: taken = alt_b_i;
         3'b101, 3'b111: taken = !alt_b_i;
         default:        taken = 1'b0;
      endcase

      dec_sel0 = (ir_opcode_i == OPC_BRANCH) || (ir_opcode_i == OPC_AUIPC) ||
                 (ir_opcode_i == OPC_JAL);
      dec_sel1 = (ir_opcode_i != OPC_OP);
      // For OP-IMM, IR[30] is an immediate bit except on shifts, where it picks SRAI.
      case (ir_opcode_i)
         OPC_OP:    dec_op = {ir_funct7_i[5], ir_funct3_i};
         OPC_OPIMM: dec_op = {(ir_funct3_i == 3'b101) && ir_funct7_i[5], ir_funct3_i};
         OPC_LUI:   dec_op = 4'hF;
         default:   dec_op = 4'h0;
      endcase
   end

   assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

   // Next-state and output decode; the cycle after reset drives everything to 0.
   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      retire      = 1'b0;
      pc_sel_o    = 2'd0;
      ir_load_o   = 1'b0;
      reg_sel_o   = 2'd0;
      reg_en_o    = 1'b0;
      alu_sel0_o  = 1'b0;
      alu_sel1_o  = 1'b0;
      alu_op_o    = 4'h0;
      addr_sel_o  = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      tmp_load_o  = 1'b0;
      dout_sel_o  = 1'b0;
      un_signed_o = 1'b0;
      trap_o      = 1'b0;
      if (!boot_q) begin
         if (state_q == S_EXEC || state_q == S_MEM_RD || state_q == S_MEM_WR) begin
            alu_sel0_o = dec_sel0;
            alu_sel1_o = dec_sel1;
            alu_op_o   = dec_op;
         end
         case (state_q)
            S_FETCH: begin
               mem_req_o = 1'b1;
               if (timeout) begin
                  mem_req_o = 1'b0;
                  trap_o    = 1'b1;
                  cause_d   = 2'd2;
                  state_d   = S_HALT;
               end else if (mem_ready_i) begin
                  ir_load_o = 1'b1;
                  state_d   = S_EXEC;
               end
            end
            S_EXEC: begin
               un_signed_o = (ir_opcode_i == OPC_BRANCH) && (ir_funct3_i[2:1] == 2'b11);
               if (illegal) begin
                  trap_o  = 1'b1;
                  cause_d = 2'd1;
                  if (HALT_ON_ILLEGAL) begin
                     state_d = S_HALT;
                  end else begin
                     pc_sel_o = 2'd1;
                     retire   = 1'b1;
                     state_d  = S_FETCH;
                  end
               end else begin
                  case (ir_opcode_i)
                     OPC_OP, OPC_OPIMM, OPC_AUIPC, OPC_LUI: begin
                        reg_en_o = 1'b1;
                        pc_sel_o = 2'd1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                     end
                     OPC_BRANCH: begin
                        pc_sel_o = taken ? 2'd2 : 2'd1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                     end
                     OPC_JAL, OPC_JALR: begin
                        reg_sel_o = 2'd2;
                        reg_en_o  = 1'b1;
                        pc_sel_o  = 2'd2;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                     end
                     OPC_FENCE: begin
                        pc_sel_o = 2'd1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                     end
                     OPC_LOAD, OPC_STORE: begin
                        if (misaligned) begin
                           trap_o  = 1'b1;
                           cause_d = 2'd3;
                           state_d = S_HALT;
                        end else if (ir_opcode_i == OPC_LOAD || (subword_st && RMW_SUBWORD)) begin
                           state_d = S_MEM_RD;
                        end else begin
                           state_d = S_MEM_WR;
                        end
                     end
                     OPC_SYSTEM: begin
                        trap_o  = 1'b1;
                        cause_d = 2'd0;
                        state_d = S_HALT;
                     end
                     default: state_d = S_HALT;
                  endcase
               end
            end
            S_MEM_RD: begin
               mem_req_o  = 1'b1;
               addr_sel_o = 1'b1;
               if (timeout) begin
                  mem_req_o = 1'b0;
                  trap_o    = 1'b1;
                  cause_d   = 2'd2;
                  state_d   = S_HALT;
               end else if (mem_ready_i) begin
                  if (ir_opcode_i == OPC_STORE) begin
                     tmp_load_o = 1'b1;
                     state_d    = S_MEM_WR;
                  end else begin
                     reg_sel_o = 2'd1;
                     reg_en_o  = 1'b1;
                     pc_sel_o  = 2'd1;
                     retire    = 1'b1;
                     state_d   = S_FETCH;
                  end
               end
            end
            S_MEM_WR: begin
               mem_req_o  = 1'b1;
               addr_sel_o = 1'b1;
               mem_we_o   = 1'b1;
               dout_sel_o = RMW_SUBWORD && subword_st;
               if (RMW_SUBWORD) begin
                  mem_be_o = 4'hF;
               end else begin
                  case (ir_funct3_i[1:0])
                     2'b00:   mem_be_o = 4'b0001 << addr_lo_i;
                     2'b01:   mem_be_o = 4'b0011 << addr_lo_i;
                     default: mem_be_o = 4'hF;
                  endcase
               end
               if (timeout) begin
                  mem_req_o = 1'b0;
                  trap_o    = 1'b1;
                  cause_d   = 2'd2;
                  state_d   = S_HALT;
               end else if (mem_ready_i) begin
                  pc_sel_o = 2'd1;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
         endcase
      end
   end

   // Stall counter and retired-instruction count next values.
   always_comb begin
      to_cnt_d  = '0;
      instret_d = instret_q + CNT_W'(retire);
      if (mem_req_o && !mem_ready_i && (state_d == state_q))
         to_cnt_d = to_cnt_q + TO_W'(1);
   end

   // State, stall counter, cause and instret registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         boot_q    <= 1'b1;
         to_cnt_q  <= '0;
         instret_q <= '0;
         cause_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         boot_q    <= 1'b0;
         to_cnt_q  <= to_cnt_d;
         instret_q <= instret_d;
         cause_q   <= cause_d;
      end
   end

   assign trap_cause_o = cause_q;
   assign instret_o    = instret_q;
   assign halted_o     = (state_q == S_HALT);
   assign state_o      = state_q;

endmodule

// File: tb/tb_rv_control_fsm_hs.sv
// Directed bench for rv_control_fsm_hs. Two instances share stimulus:
// dut_a uses read-modify-write stores and halts on illegal instructions,
// dut_b uses byte-enable stores, retires illegal instructions as NOPs and
// has a 2-bit instret so its wrap is visible.
module tb_rv_control_fsm_hs;

   logic       clk;
   logic       rst;
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       alt, aeq, rdy;
   logic [1:0] alo;

   logic [1:0]  a_pc_sel, a_reg_sel, a_trap_cause;
   logic        a_ir_load, a_reg_en, a_alu_sel0, a_alu_sel1, a_addr_sel, a_mem_req, a_mem_we;
   logic        a_tmp_load, a_dout_sel, a_un_signed, a_trap, a_halted;
   logic [3:0]  a_alu_op, a_mem_be;
   logic [31:0] a_instret;
   logic [2:0]  a_state;

   logic [1:0]  b_pc_sel, b_reg_sel, b_trap_cause;
   logic        b_ir_load, b_reg_en, b_alu_sel0, b_alu_sel1, b_addr_sel, b_mem_req, b_mem_we;
   logic        b_tmp_load, b_dout_sel, b_un_signed, b_trap, b_halted;
   logic [3:0]  b_alu_op, b_mem_be;
   logic [1:0]  b_instret;
   logic [2:0]  b_state;

   int checks = 0;
   int errors = 0;

   rv_control_fsm_hs #(.TIMEOUT_CYCLES(4), .RMW_SUBWORD(1'b1), .HALT_ON_ILLEGAL(1'b1), .CNT_W(32)) dut_a (
      .clk_i(clk), .rst_i(rst), .ir_opcode_i(opc), .ir_funct3_i(f3), .ir_funct7_i(f7),
      .alt_b_i(alt), .aeq_b_i(aeq), .addr_lo_i(alo), .mem_ready_i(rdy),
      .pc_sel_o(a_pc_sel), .ir_load_o(a_ir_load), .reg_sel_o(a_reg_sel), .reg_en_o(a_reg_en),
      .alu_sel0_o(a_alu_sel0), .alu_sel1_o(a_alu_sel1), .alu_op_o(a_alu_op), .addr_sel_o(a_addr_sel),
      .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be), .tmp_load_o(a_tmp_load),
      .dout_sel_o(a_dout_sel), .un_signed_o(a_un_signed), .trap_o(a_trap), .trap_cause_o(a_trap_cause),
      .halted_o(a_halted), .instret_o(a_instret), .state_o(a_state)
   );

   rv_control_fsm_hs #(.TIMEOUT_CYCLES(4), .RMW_SUBWORD(1'b0), .HALT_ON_ILLEGAL(1'b0), .CNT_W(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .ir_opcode_i(opc), .ir_funct3_i(f3), .ir_funct7_i(f7),
      .alt_b_i(alt), .aeq_b_i(aeq), .addr_lo_i(alo), .mem_ready_i(rdy),
      .pc_sel_o(b_pc_sel), .ir_load_o(b_ir_load), .reg_sel_o(b_reg_sel), .reg_en_o(b_reg_en),
      .alu_sel0_o(b_alu_sel0), .alu_sel1_o(b_alu_sel1), .alu_op_o(b_alu_op), .addr_sel_o(b_addr_sel),
      .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be), .tmp_load_o(b_tmp_load),
      .dout_sel_o(b_dout_sel), .un_signed_o(b_un_signed), .trap_o(b_trap), .trap_cause_o(b_trap_cause),
      .halted_o(b_halted), .instret_o(b_instret), .state_o(b_state)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 2 time units after the edge.
   task automatic next();
      @(posedge clk);
      #2;
   endtask

   // Two reset edges, then release; returns inside the post-reset cycle.
   task automatic do_reset();
      rst = 1'b1;
      opc = 7'h13; f3 = 3'd0; f7 = 7'd0;
      alt = 1'b0; aeq = 1'b0; alo = 2'd0; rdy = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // ADD then SUB, mem_ready tied high
      do_reset();
      chk("rst_mem_req", 32'(a_mem_req), 0);
      chk("rst_state", 32'(a_state), 0);
      chk("rst_instret", a_instret, 0);
      chk("rst_cause", 32'(a_trap_cause), 0);
      chk("rst_halted", 32'(a_halted), 0);
      opc = 7'h33; f3 = 3'b000; f7 = 7'h00; rdy = 1'b1; #1;
      chk("rst_ir_load", 32'(a_ir_load), 0);
      chk("rst_pc_sel", 32'(a_pc_sel), 0);
      next();
      chk("add_f_mem_req", 32'(a_mem_req), 1);
      chk("add_f_ir_load", 32'(a_ir_load), 1);
      chk("add_f_addr_sel", 32'(a_addr_sel), 0);
      chk("add_f_mem_we", 32'(a_mem_we), 0);
      next();
      chk("add_e_state", 32'(a_state), 1);
      chk("add_e_reg_en", 32'(a_reg_en), 1);
      chk("add_e_reg_sel", 32'(a_reg_sel), 0);
      chk("add_e_pc_sel", 32'(a_pc_sel), 1);
      chk("add_e_alu_op", 32'(a_alu_op), 0);
      chk("add_e_mem_req", 32'(a_mem_req), 0);
      next();
      chk("add_ret_state", 32'(a_state), 0);
      chk("add_ret_instret", a_instret, 1);
      chk("add_ret_reg_en", 32'(a_reg_en), 0);
      f7 = 7'h20; #1;
      next();
      chk("sub_alu_op", 32'(a_alu_op), 8);
      next();
      chk("sub_instret", a_instret, 2);

      // LW with three stalled cycles in MEM_RD
      do_reset();
      opc = 7'h03; f3 = 3'b010; alo = 2'd0; rdy = 1'b1; #1;
      next();
      next();
      chk("lw_e_state", 32'(a_state), 1);
      chk("lw_e_mem_req", 32'(a_mem_req), 0);
      rdy = 1'b0;
      next();
      for (int i = 0; i < 3; i++) begin
         chk("lw_stall_mem_req", 32'(a_mem_req), 1);
         chk("lw_stall_addr_sel", 32'(a_addr_sel), 1);
         chk("lw_stall_mem_we", 32'(a_mem_we), 0);
         chk("lw_stall_reg_en", 32'(a_reg_en), 0);
         chk("lw_stall_pc_sel", 32'(a_pc_sel), 0);
         next();
      end
      rdy = 1'b1; #1;
      chk("lw_done_mem_req", 32'(a_mem_req), 1);
      chk("lw_done_addr_sel", 32'(a_addr_sel), 1);
      chk("lw_done_reg_en", 32'(a_reg_en), 1);
      chk("lw_done_reg_sel", 32'(a_reg_sel), 1);
      chk("lw_done_pc_sel", 32'(a_pc_sel), 1);
      next();
      chk("lw_ret_state", 32'(a_state), 0);
      chk("lw_ret_instret", a_instret, 1);

      // SB at addr_lo=2: RMW on dut_a, byte-enable write on dut_b
      do_reset();
      opc = 7'h23; f3 = 3'b000; alo = 2'd2; rdy = 1'b1; #1;
      next();
      next();
      chk("sb_e_mem_req", 32'(a_mem_req), 0);
      next();
      chk("sb_a_rd_state", 32'(a_state), 2);
      chk("sb_a_rd_mem_we", 32'(a_mem_we), 0);
      chk("sb_a_rd_tmp_load", 32'(a_tmp_load), 1);
      chk("sb_a_rd_pc_sel", 32'(a_pc_sel), 0);
      chk("sb_b_wr_state", 32'(b_state), 3);
      chk("sb_b_wr_mem_we", 32'(b_mem_we), 1);
      chk("sb_b_wr_mem_be", 32'(b_mem_be), 4);
      chk("sb_b_wr_dout_sel", 32'(b_dout_sel), 0);
      chk("sb_b_wr_pc_sel", 32'(b_pc_sel), 1);
      next();
      chk("sb_a_wr_state", 32'(a_state), 3);
      chk("sb_a_wr_mem_we", 32'(a_mem_we), 1);
      chk("sb_a_wr_mem_be", 32'(a_mem_be), 15);
      chk("sb_a_wr_dout_sel", 32'(a_dout_sel), 1);
      chk("sb_a_wr_tmp_load", 32'(a_tmp_load), 0);
      chk("sb_a_wr_pc_sel", 32'(a_pc_sel), 1);
      chk("sb_b_ret_instret", 32'(b_instret), 1);
      next();
      chk("sb_a_ret_state", 32'(a_state), 0);
      chk("sb_a_ret_instret", a_instret, 1);

      // SH at addr_lo=2 on dut_b
      do_reset();
      opc = 7'h23; f3 = 3'b001; alo = 2'd2; rdy = 1'b1; #1;
      next();
      next();
      next();
      chk("sh_b_mem_be", 32'(b_mem_be), 12);

      // BEQ taken / not taken, BLTU, FENCE, instret wrap on dut_b
      do_reset();
      opc = 7'h63; f3 = 3'b000; aeq = 1'b1; rdy = 1'b1; #1;
      next();
      next();
      chk("beq_t_pc_sel", 32'(a_pc_sel), 2);
      chk("beq_t_alu_sel0", 32'(a_alu_sel0), 1);
      chk("beq_t_alu_sel1", 32'(a_alu_sel1), 1);
      chk("beq_t_un_signed", 32'(a_un_signed), 0);
      chk("beq_t_reg_en", 32'(a_reg_en), 0);
      next();
      aeq = 1'b0; #1;
      next();
      chk("beq_nt_pc_sel", 32'(a_pc_sel), 1);
      next();
      f3 = 3'b110; alt = 1'b1; #1;
      next();
      chk("bltu_un_signed", 32'(a_un_signed), 1);
      chk("bltu_pc_sel", 32'(a_pc_sel), 2);
      next();
      chk("bltu_b_instret", 32'(b_instret), 3);
      opc = 7'h0F; f3 = 3'b000; #1;
      next();
      chk("fence_pc_sel", 32'(a_pc_sel), 1);
      chk("fence_reg_en", 32'(a_reg_en), 0);
      next();
      chk("fence_a_instret", a_instret, 4);
      chk("wrap_b_instret", 32'(b_instret), 0);

      // Bus timeout while fetching
      do_reset();
      rdy = 1'b0; #1;
      next();
      for (int i = 0; i < 4; i++) begin
         chk("to_stall_mem_req", 32'(a_mem_req), 1);
         chk("to_stall_trap", 32'(a_trap), 0);
         next();
      end
      chk("to_a_trap", 32'(a_trap), 1);
      chk("to_b_trap", 32'(b_trap), 1);
      chk("to_a_ir_load", 32'(a_ir_load), 0);
      next();
      chk("to_a_halted", 32'(a_halted), 1);
      chk("to_a_state", 32'(a_state), 4);
      chk("to_a_cause", 32'(a_trap_cause), 2);
      chk("to_a_trap_low", 32'(a_trap), 0);
      chk("to_a_mem_req", 32'(a_mem_req), 0);
      chk("to_b_cause", 32'(b_trap_cause), 2);
      rdy = 1'b1; #1;
      next();
      next();
      chk("to_hold_halted", 32'(a_halted), 1);
      chk("to_hold_mem_req", 32'(a_mem_req), 0);
      chk("to_hold_ir_load", 32'(a_ir_load), 0);

      // LH misaligned
      do_reset();
      opc = 7'h03; f3 = 3'b001; alo = 2'd1; rdy = 1'b1; #1;
      next();
      next();
      chk("lh_trap", 32'(a_trap), 1);
      chk("lh_mem_req", 32'(a_mem_req), 0);
      next();
      chk("lh_cause", 32'(a_trap_cause), 3);
      chk("lh_halted", 32'(a_halted), 1);
      chk("lh_mem_req_halt", 32'(a_mem_req), 0);

      // Illegal opcode 7'h7F
      do_reset();
      opc = 7'h7F; rdy = 1'b1; #1;
      next();
      next();
      chk("ill_a_trap", 32'(a_trap), 1);
      chk("ill_a_pc_sel", 32'(a_pc_sel), 0);
      chk("ill_b_trap", 32'(b_trap), 1);
      chk("ill_b_pc_sel", 32'(b_pc_sel), 1);
      next();
      chk("ill_b_state", 32'(b_state), 0);
      chk("ill_b_instret", 32'(b_instret), 1);
      chk("ill_b_cause", 32'(b_trap_cause), 1);
      chk("ill_b_halted", 32'(b_halted), 0);
      chk("ill_a_halted", 32'(a_halted), 1);
      chk("ill_a_cause", 32'(a_trap_cause), 1);
      chk("ill_a_instret", a_instret, 0);

      // OP with funct7=0000001 is not RV32I
      do_reset();
      opc = 7'h33; f3 = 3'b000; f7 = 7'h01; rdy = 1'b1; #1;
      next();
      next();
      chk("mul_trap", 32'(a_trap), 1);
      chk("mul_reg_en", 32'(a_reg_en), 0);
      next();
      chk("mul_cause", 32'(a_trap_cause), 1);

      // ECALL
      do_reset();
      opc = 7'h73; f3 = 3'b000; f7 = 7'h00; rdy = 1'b1; #1;
      next();
      next();
      chk("ecall_trap", 32'(a_trap), 1);
      next();
      chk("ecall_cause", 32'(a_trap_cause), 0);
      chk("ecall_halted", 32'(a_halted), 1);

      // Reset asserted in the middle of a fetch handshake
      do_reset();
      rdy = 1'b0; #1;
      next();
      chk("rmid_mem_req_before", 32'(a_mem_req), 1);
      rst = 1'b1; #1;
      next();
      chk("rmid_mem_req_after", 32'(a_mem_req), 0);
      chk("rmid_state", 32'(a_state), 0);
      rst = 1'b0; #1;
      next();
      chk("rmid_refetch", 32'(a_mem_req), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
